// File: rtl/frame_config_pkg.sv
// Shared types and constants for the frame configuration loader.
// Header layout: [31:28] opcode, [15:8] column, [4:0] frame.
package frame_config_pkg;

  typedef enum logic [1:0] {
    HUNT,
    CMD,
    LOAD,
    STROBE
  } state_t;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_WRITE  = 4'h1;
  localparam logic [3:0] OP_DESYNC = 4'hF;

  localparam int OPC_LSB = 28;
  localparam int OPC_W   = 4;
  localparam int COL_LSB = 8;
  localparam int COL_W   = 8;
  localparam int FRM_LSB = 0;
  localparam int FRM_W   = 5;

  localparam logic [31:0] SYNC_WORD_DEF = 32'hFAB0_FAB1;

endpackage

// File: rtl/frame_strobe_decode.sv
// Column/frame address to one-hot frame strobe vector.
// All bits are low while i_en is low.
module frame_strobe_decode
  import frame_config_pkg::*;
#(
  parameter int NUM_COLS       = 4,
  parameter int FRAMES_PER_COL = 20
) (
  input  logic                               i_en,
  input  logic [COL_W-1:0]                   i_col,
  input  logic [FRM_W-1:0]                   i_frm,
  output logic [NUM_COLS*FRAMES_PER_COL-1:0] o_strobe
);

  localparam int N = NUM_COLS * FRAMES_PER_COL;

  logic [31:0] w_idx;

  assign w_idx = 32'(i_col) * 32'(FRAMES_PER_COL)
               + 32'(i_frm);

  always_comb begin
    o_strobe = '0;
    for (int i = 0; i < N; i++) begin
      o_strobe[i] = i_en && (w_idx == 32'(i));
    end
  end

endmodule

// File: rtl/frame_config_ctrl.sv
// Bitstream loader: hunts for sync, parses write-frame headers,
// assembles frame data and pulses one frame strobe per frame.
module frame_config_ctrl
  import frame_config_pkg::*;
#(
  parameter int          FRAME_WORDS    = 4,
  parameter int          NUM_COLS       = 4,
  parameter int          FRAMES_PER_COL = 20,
  parameter int          STROBE_CYCLES  = 2,
  parameter logic [31:0] SYNC_WORD      = SYNC_WORD_DEF
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [31:0]                        s_data,
  input  logic                               s_valid,
  output logic                               s_ready,
  output logic [32*FRAME_WORDS-1:0]          frame_data,
  output logic [NUM_COLS*FRAMES_PER_COL-1:0] frame_strobe,
  output logic                               cfg_busy,
  output logic                               cfg_done,
  output logic                               cfg_err,
  output logic [15:0]                        frame_count
);

  localparam int WW = (FRAME_WORDS > 1) ?
                      $clog2(FRAME_WORDS) : 1;
  localparam int SW = (STROBE_CYCLES > 1) ?
                      $clog2(STROBE_CYCLES) : 1;
  localparam logic [WW-1:0] W_LAST = WW'(FRAME_WORDS - 1);
  localparam logic [SW-1:0] S_LAST = SW'(STROBE_CYCLES - 1);

  state_t r_state;
  state_t w_next;

  logic [COL_W-1:0]          r_col;
  logic [FRM_W-1:0]          r_frm;
  logic [WW-1:0]             r_wcnt;
  logic [SW-1:0]             r_scnt;
  logic [32*FRAME_WORDS-1:0] r_data;
  logic                      r_done;
  logic                      r_err;
  logic [15:0]               r_count;

  logic             w_acc;
  logic [OPC_W-1:0] w_opc;
  logic [COL_W-1:0] w_col;
  logic [FRM_W-1:0] w_frm;
  logic             w_sync;
  logic             w_in_rng;
  logic             w_wr;
  logic             w_desync;
  logic             w_bad;
  logic             w_wlast;
  logic             w_slast;
  logic             w_strobe_en;

  assign w_acc    = s_valid & s_ready;
  assign w_opc    = s_data[OPC_LSB +: OPC_W];
  assign w_col    = s_data[COL_LSB +: COL_W];
  assign w_frm    = s_data[FRM_LSB +: FRM_W];
  assign w_sync   = (s_data == SYNC_WORD);
  assign w_in_rng = (int'(w_col) < NUM_COLS) &&
                    (int'(w_frm) < FRAMES_PER_COL);

  // Sync takes priority: its opcode nibble would read as DESYNC.
  assign w_wr     = !w_sync && (w_opc == OP_WRITE) && w_in_rng;
  assign w_desync = !w_sync && (w_opc == OP_DESYNC);
  assign w_bad    = !w_sync && (w_opc != OP_NOP) &&
                    !w_wr && !w_desync;
  assign w_wlast  = (r_wcnt == W_LAST);
  assign w_slast  = (r_scnt == S_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      HUNT: begin
        if (w_acc && w_sync) w_next = CMD;
      end
      CMD: begin
        if (w_acc) begin
          unique case (1'b1)
            w_wr:            w_next = LOAD;
            w_desync, w_bad: w_next = HUNT;
            default:         w_next = CMD;
          endcase
        end
      end
      LOAD: begin
        if (w_acc && w_wlast) w_next = STROBE;
      end
      STROBE: begin
        if (w_slast) w_next = CMD;
      end
      default: w_next = HUNT;
    endcase
  end

  always_comb begin
    s_ready     = (r_state != STROBE);
    cfg_busy    = (r_state != HUNT);
    w_strobe_en = (r_state == STROBE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col   <= '0;
      r_frm   <= '0;
      r_wcnt  <= '0;
      r_scnt  <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_count <= '0;
    end else begin
      unique case (r_state)
        HUNT: begin
          if (w_acc && w_sync) begin
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_count <= '0;
          end
        end
        CMD: begin
          if (w_acc && w_wr) begin
            r_col  <= w_col;
            r_frm  <= w_frm;
            r_wcnt <= '0;
          end
          if (w_acc && w_desync) r_done <= 1'b1;
          if (w_acc && w_bad)    r_err  <= 1'b1;
        end
        LOAD: begin
          if (w_acc) begin
            // First word of a frame lands in the top row.
            for (int k = 0; k < FRAME_WORDS; k++) begin
              if (r_wcnt == WW'(k))
                r_data[32*(FRAME_WORDS-k)-1 -: 32] <= s_data;
            end
            r_wcnt <= w_wlast ? '0 : r_wcnt + 1'b1;
          end
        end
        STROBE: begin
          r_scnt <= w_slast ? '0 : r_scnt + 1'b1;
          if (w_slast && (r_count != 16'hFFFF))
            r_count <= r_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

  frame_strobe_decode #(
    .NUM_COLS       (NUM_COLS),
    .FRAMES_PER_COL (FRAMES_PER_COL)
  ) u_dec (
    .i_en     (w_strobe_en),
    .i_col    (r_col),
    .i_frm    (r_frm),
    .o_strobe (frame_strobe)
  );

  assign frame_data  = r_data;
  assign cfg_done    = r_done;
  assign cfg_err     = r_err;
  assign frame_count = r_count;

endmodule

// File: tb/tb_frame_config_ctrl.sv
// Self-checking bench for frame_config_ctrl: directed scenarios plus
// random traffic against a transaction-level reference model.
module tb_frame_config_ctrl;

  localparam int FW  = 4;
  localparam int NC  = 4;
  localparam int FPC = 20;
  localparam int SC  = 2;
  localparam int N   = NC * FPC;
  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   s_data;
  logic          s_valid;
  logic          s_ready;
  logic [127:0]  frame_data;
  logic [N-1:0]  frame_strobe;
  logic          cfg_busy;
  logic          cfg_done;
  logic          cfg_err;
  logic [15:0]   frame_count;

  always #5 clk = ~clk;

  frame_config_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .frame_data   (frame_data),
    .frame_strobe (frame_strobe),
    .cfg_busy     (cfg_busy),
    .cfg_done     (cfg_done),
    .cfg_err      (cfg_err),
    .frame_count  (frame_count)
  );

  int checks   = 0;
  int failures = 0;
  bit run_cmp  = 1'b0;
  int last_waits;

  // Reference model: synced flag, load progress, strobe countdown.
  bit          m_sync;
  int          m_k;
  int          m_sl;
  int          m_idx;
  logic [31:0] m_d [FW];
  int          m_cnt;
  bit          m_done;
  bit          m_err;

  function automatic void model_reset();
    m_sync = 0; m_k = -1; m_sl = 0; m_idx = 0;
    m_cnt = 0; m_done = 0; m_err = 0;
    for (int i = 0; i < FW; i++) m_d[i] = '0;
  endfunction

  function automatic void model_step(input logic v,
                                     input logic [31:0] d);
    int c;
    int f;
    if (m_sl > 0) begin
      m_sl--;
      if (m_sl == 0 && m_cnt < 65535) m_cnt++;
    end else if (v) begin
      c = int'(d[15:8]);
      f = int'(d[4:0]);
      if (!m_sync) begin
        if (d == SYNC) begin
          m_sync = 1; m_done = 0; m_err = 0; m_cnt = 0;
        end
      end else if (m_k >= 0) begin
        m_d[m_k] = d;
        m_k++;
        if (m_k == FW) begin
          m_k = -1;
          m_sl = SC;
        end
      end else if (d == SYNC || d[31:28] == 4'h0) begin
      end else if (d[31:28] == 4'h1 && c < NC && f < FPC) begin
        m_idx = c * FPC + f;
        m_k = 0;
      end else if (d[31:28] == 4'hF) begin
        m_done = 1; m_sync = 0;
      end else begin
        m_err = 1; m_sync = 0;
      end
    end
  endfunction

  function automatic logic [127:0] exp_data();
    logic [127:0] r = '0;
    for (int k = 0; k < FW; k++) r = (r << 32) | 128'(m_d[k]);
    return r;
  endfunction

  function automatic logic [N-1:0] exp_strobe();
    logic [N-1:0] r = '0;
    if (m_sl > 0) r[m_idx] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else model_step(s_valid, s_data);
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      if (!rst_n) model_reset();
      chk("m_ready", 128'(s_ready), 128'(m_sl == 0));
      chk("m_strobe", 128'(frame_strobe), 128'(exp_strobe()));
      chk("m_data", frame_data, exp_data());
      chk("m_busy", 128'(cfg_busy), 128'(m_sync));
      chk("m_done", 128'(cfg_done), 128'(m_done));
      chk("m_err", 128'(cfg_err), 128'(m_err));
      chk("m_count", 128'(frame_count), 128'(m_cnt));
    end
  end

  task automatic send(input logic [31:0] w);
    int n = 0;
    s_valid = 1'b1;
    s_data  = w;
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL send_timeout act=%0d exp=<100", n);
    end
    last_waits = n;
    @(negedge clk);
  endtask

  function automatic logic [31:0] hdr(input int c, input int f);
    return {4'h1, 12'h000, 8'(c), 3'b000, 5'(f)};
  endfunction

  function automatic logic [31:0] pick();
    int r = int'($urandom % 100);
    if (r < 20) return SYNC;
    if (r < 55)
      return {4'h1, 12'($urandom), 8'($urandom % 5),
              3'($urandom), 5'($urandom % 22)};
    if (r < 62) return 32'hF000_0000;
    if (r < 70) return 32'h0000_0000;
    return $urandom;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  logic [N-1:0] one;
  localparam logic [127:0] DATA_A =
    128'h000000A0_000000A1_000000A2_000000A3;

  initial begin
    one = 1;
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    run_cmp = 1'b1;
    chk("rst_ready", 128'(s_ready), 128'd1);
    chk("rst_count", 128'(frame_count), 128'd0);
    chk("rst_strobe", 128'(frame_strobe), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single frame to col 2 / frame 3
    send(32'h1234_5678); send(SYNC); send(32'h1000_0203);
    for (int i = 0; i < FW; i++) send(32'hA0 + 32'(i));
    s_valid = 1'b0;
    chk("t1_strobe", 128'(frame_strobe), 128'(one << 43));
    chk("t1_data", frame_data, DATA_A);
    chk("t1_busy", 128'(cfg_busy), 128'd1);
    chk("t1_ready", 128'(s_ready), 128'd0);
    @(negedge clk);
    chk("t1_strobe2", 128'(frame_strobe), 128'(one << 43));
    @(negedge clk);
    chk("t1_strobe_off", 128'(frame_strobe), 128'd0);
    chk("t1_count", 128'(frame_count), 128'd1);

    // Back-to-back frames with s_valid held high
    send(hdr(0, 0));
    for (int i = 0; i < FW; i++) send(32'hB0 + 32'(i));
    chk("t2_strobe0", 128'(frame_strobe), 128'(one));
    send(hdr(3, 19));
    chk("t2_hdr_wait", 128'(last_waits), 128'(SC));
    for (int i = 0; i < FW; i++) send(32'hC0 + 32'(i));
    s_valid = 1'b0;
    chk("t2_strobe79", 128'(frame_strobe), 128'(one << 79));
    chk("t2_data", frame_data,
        128'h000000C0_000000C1_000000C2_000000C3);
    repeat (2) @(negedge clk);
    chk("t2_count", 128'(frame_count), 128'd3);

    // Out-of-range column
    send(32'h1000_0500);
    s_valid = 1'b0;
    chk("t3_err", 128'(cfg_err), 128'd1);
    chk("t3_busy", 128'(cfg_busy), 128'd0);
    chk("t3_nostrobe", 128'(frame_strobe), 128'd0);
    send(SYNC);
    s_valid = 1'b0;
    chk("t3_err_clr", 128'(cfg_err), 128'd0);
    chk("t3_count_clr", 128'(frame_count), 128'd0);

    // Unknown opcode, then resync and desync
    send(32'h7000_0000);
    s_valid = 1'b0;
    chk("t4_err", 128'(cfg_err), 128'd1);
    send(SYNC); send(32'hF000_0000);
    s_valid = 1'b0;
    chk("t4_done", 128'(cfg_done), 128'd1);
    chk("t4_busy", 128'(cfg_busy), 128'd0);
    chk("t4_err_clr", 128'(cfg_err), 128'd0);

    // Gapped s_valid during LOAD, words offered during STROBE
    send(SYNC); send(hdr(2, 3));
    for (int i = 0; i < FW; i++) begin
      s_valid = 1'b0;
      repeat ($urandom % 3) @(negedge clk);
      send(32'hA0 + 32'(i));
    end
    s_data = 32'h0;
    chk("t5_strobe", 128'(frame_strobe), 128'(one << 43));
    chk("t5_data", frame_data, DATA_A);
    chk("t5_ready", 128'(s_ready), 128'd0);
    @(negedge clk);
    chk("t5_ready2", 128'(s_ready), 128'd0);
    @(negedge clk);
    s_valid = 1'b0;
    chk("t5_strobe_off", 128'(frame_strobe), 128'd0);
    chk("t5_count", 128'(frame_count), 128'd1);

    // Reset during first strobe cycle
    send(hdr(1, 5));
    for (int i = 0; i < FW; i++) send(32'hD0 + 32'(i));
    s_valid = 1'b0;
    chk("t6_pre", 128'(frame_strobe), 128'(one << 25));
    #1 rst_n = 1'b0;
    #1;
    chk("t6_strobe", 128'(frame_strobe), 128'd0);
    chk("t6_ready", 128'(s_ready), 128'd1);
    chk("t6_busy", 128'(cfg_busy), 128'd0);
    chk("t6_count", 128'(frame_count), 128'd0);
    chk("t6_data", frame_data, 128'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    send(32'h1000_0203);
    for (int i = 0; i < FW; i++) send(32'hE0 + 32'(i));
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_nosync_cnt", 128'(frame_count), 128'd0);
    chk("t6_nosync_data", frame_data, 128'd0);
    chk("t6_nosync_busy", 128'(cfg_busy), 128'd0);

    // Random traffic
    for (int c = 0; c < 800; c++) begin
      s_valid = ($urandom % 4) != 0;
      s_data  = pick();
      @(negedge clk);
    end
    s_valid = 1'b0;
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
